fpacc_seq: RTL and testbench
============================

# fpacc_seq

Sequencer that drives the team's multi-cycle floating-point adder through its `start`/`done` handshake, reducing a stream of IEEE-754 single-precision operands into one sum per packet. Upstream presents operands on a valid/ready stream with a `last` marker; the block pulses `start`, waits for `done`, feeds the returned `sum` back as the next `a` operand, and emits the packet total on a valid/ready output. It is the initiator side of the adder interface and sits between the operand buffer and the result sink.

## Interface
- `TIMEOUT`, 64: max cycles to wait for `add_done` after a start pulse before aborting the packet.
- `CNT_W`, 8: width of the per-packet element counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block accepts operand this cycle.
- `in_data`  in  32  operand, IEEE-754 single.
- `in_last`  in  1  operand is final element of packet.
- `add_start`  out  1  one-cycle start pulse to adder.
- `add_a`, `add_b`  out  32 each  adder operands.
- `add_sum`  in  32  adder result.
- `add_done`  in  1  adder result valid (level).
- `out_valid`  out  1  packet result valid.
- `out_ready`  in  1  sink accepts result.
- `out_data`  out  32  packet sum.
- `out_count`  out  CNT_W  elements in packet (saturating at all-ones).
- `out_err`  out  1  packet aborted on adder timeout; `out_data` holds partial sum.

## Operation
- States: IDLE, ACC, ISSUE, WAIT, OUT, DRAIN.
- IDLE: `in_ready`=1. On handshake: acc<=`in_data`, count<=1; if `in_last` -> OUT, else -> ACC. No adder call for first element.
- ACC: `in_ready`=1. On handshake: b_reg<=`in_data`, last_reg<=`in_last`, count<=count+1 (saturating) -> ISSUE.
- ISSUE: `add_start`=1 for exactly this one cycle, `add_a`=acc, `add_b`=b_reg; timer<=0 -> WAIT.
- WAIT: `add_a`/`add_b` held stable. `add_done` sampled only here (never in the ISSUE cycle). On `add_done`=1: acc<=`add_sum`; last_reg ? -> OUT : -> ACC. Else timer+1; when timer reaches TIMEOUT-1 without done: err<=1, -> OUT if last_reg else DRAIN.
- DRAIN: `in_ready`=1, operands discarded; on handshake with `in_last` -> OUT.
- OUT: `out_valid`=1, `out_data`=acc, `out_count`=count, `out_err`=err; all stable while `out_ready`=0. On handshake: err<=0 -> IDLE.
- `in_ready`=0 in ISSUE, WAIT, OUT. `add_a`/`add_b` drive acc/b_reg in all states; only the ISSUE pulse is meaningful.
- No floating-point arithmetic in this block; sums are bit-exact copies of `add_sum`.

## Timing
- Reset (async assert, sync release): state IDLE; `in_ready`=1 after release; `add_start`=0, `add_a`=`add_b`=0, `out_valid`=0, `out_data`=0, `out_count`=0, `out_err`=0, timer=0.
- Single-element packet: input handshake cycle N -> `out_valid` at N+1.
- Per additional element: handshake N, `add_start` at N+1, done earliest sampled N+2; with adder latency L cycles from start, acc update at N+1+L, next `in_ready` at N+2+L.
- `add_start` never high two consecutive cycles; never reissued while WAIT.
- Reset mid-WAIT: block returns to IDLE immediately; adder is not notified (its next start reinitialises it).
- `out_count` saturates at 2^CNT_W-1; accumulation continues.
- Timeout fires on the TIMEOUT-th WAIT cycle without done; a done arriving the same cycle wins (no error).

## Test plan
- Single element 0x3F800000 with last -> `out_valid` next cycle, `out_data`=0x3F800000, `out_count`=1, `out_err`=0, `add_start` never pulsed.
- Packet 1.0, 2.0, 4.0 (0x3F800000, 0x40000000, 0x40800000) with adder model latency 5 -> two start pulses with a/b = (0x3F800000,0x40000000), (0x40400000,0x40800000); `out_data`=0x40E00000, count 3.
- Backpressure: `out_ready`=0 for 10 cycles on result -> `out_*` stable, `in_ready`=0 throughout, result accepted on release, next packet starts.
- Timeout: TIMEOUT=8, model never asserts done, packet of 4 -> `out_err`=1 after 8 WAIT cycles, remaining 2 operands drained, `out_data`=first operand, count reflects handshakes to that point.
- Done on final timeout cycle -> no error, acc updated.
- Assert `reset` low during WAIT -> all outputs at reset values immediately; a subsequent packet 3.0+(-3.0) yields adder-returned sum exactly.

Source files
------------

// File: rtl/fpacc_seq.sv
// Sequencer that reduces a packet of single-precision operands through an external
// multi-cycle adder via a start/done handshake, emitting one sum per packet.
module fpacc_seq #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             add_start,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    input  logic             add_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAcc,
        StIssue,
        StWait,
        StOut,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       b_q, b_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TW-1:0]     timer_q, timer_d;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        last_d    = last_q;
        err_d     = err_q;
        count_d   = count_q;
        timer_d   = timer_q;
        in_ready  = 1'b0;
        add_start = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                // First element seeds the accumulator without an adder call.
                if (in_valid) begin
                    acc_d   = in_data;
                    count_d = CNT_W'(1);
                    state_d = in_last ? StOut : StAcc;
                end
            end
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d    = in_data;
                    last_d = in_last;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                add_start = 1'b1;
                timer_d   = '0;
                state_d   = StWait;
            end
            StWait: begin
                // A done arriving on the last allowed cycle takes priority over the timeout.
                if (add_done) begin
                    acc_d   = add_sum;
                    state_d = last_q ? StOut : StAcc;
                end else if (timer_q == TimerMax) begin
                    err_d   = 1'b1;
                    state_d = last_q ? StOut : StDrain;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDrain: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            last_q  <= last_d;
            err_q   <= err_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    assign add_a     = acc_q;
    assign add_b     = b_q;
    assign out_data  = acc_q;
    assign out_count = count_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_fpacc_seq.sv
// Directed bench for fpacc_seq with a latency-programmable adder model and
// scoreboards for adder calls and packet results.
module tb_fpacc_seq;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             add_start;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum = '0;
    logic             add_done = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    fpacc_seq #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_done  (add_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_starts = 0;
    int lat = 1;

    logic [63:0] start_q[$];  // expected {a, b} per adder call
    logic [31:0] sum_q[$];    // sums the adder model will return
    logic [34:0] out_q[$];    // expected {err, count(2), data}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Adder model: done rises `lat` cycles after the start pulse and stays high until next start.
    int k = 0;
    logic active = 1'b0;
    always @(posedge clk) begin
        if (add_start) begin
            k <= 1;
            active <= 1'b1;
            add_done <= (lat <= 1);
            if (sum_q.size() > 0) add_sum <= sum_q.pop_front();
            else add_sum <= 32'hDEADBEEF;
        end else if (active) begin
            k <= k + 1;
            add_done <= (k + 1 >= lat);
        end
    end

    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (add_start) begin
            logic [63:0] e;
            n_starts++;
            chk("start_consec", {31'd0, prev_start}, 32'd0);
            if (start_q.size() == 0) begin
                chk("start_unexpected", 32'd1, 32'd0);
            end else begin
                e = start_q.pop_front();
                chk("add_a", add_a, e[63:32]);
                chk("add_b", add_b, e[31:0]);
            end
        end
        prev_start = add_start;
        if (out_valid && out_ready) begin
            logic [34:0] o;
            if (out_q.size() == 0) begin
                chk("out_unexpected", 32'd1, 32'd0);
            end else begin
                o = out_q.pop_front();
                chk("out_data", out_data, o[31:0]);
                chk("out_count", {30'd0, out_count}, {30'd0, o[33:32]});
                chk("out_err", {31'd0, out_err}, {31'd0, o[34]});
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, output int waits);
        logic hs;
        hs = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                hs = 1'b1;
                break;
            end
            waits++;
        end
        if (!hs) chk("in_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_out(input logic [31:0] d, input logic [1:0] c, input logic e);
        out_q.push_back({e, c, d});
    endtask

    task automatic wait_out_empty(input string tag);
        for (int i = 0; i < 300 && out_q.size() != 0; i++) @(negedge clk);
        chk(tag, out_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s0;

        // Reset values
        @(negedge clk);
        chk("rst_add_start", {31'd0, add_start}, 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", {30'd0, out_count}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single element packet: result next cycle, no adder call
        s0 = n_starts;
        expect_out(32'h3F800000, 2'd1, 1'b0);
        send(32'h3F800000, 1'b1, w);
        @(negedge clk);
        chk("single_next_cycle_valid", {31'd0, out_valid}, 32'd1);
        wait_out_empty("single_drain");
        chk("single_no_start", n_starts - s0, 32'd0);

        // 1.0 + 2.0 + 4.0, adder latency 5
        lat = 5;
        start_q.push_back({32'h3F800000, 32'h40000000});
        start_q.push_back({32'h40400000, 32'h40800000});
        sum_q.push_back(32'h40400000);
        sum_q.push_back(32'h40E00000);
        expect_out(32'h40E00000, 2'd3, 1'b0);
        send(32'h3F800000, 1'b0, w);
        send(32'h40000000, 1'b0, w);
        send(32'h40800000, 1'b1, w);
        chk("lat5_ready_gap", w, 32'd6);
        wait_out_empty("sum3_drain");

        // Backpressure on the result
        out_ready = 1'b0;
        expect_out(32'h40000000, 2'd1, 1'b0);
        send(32'h40000000, 1'b1, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_data", out_data, 32'h40000000);
            chk("bp_out_count", {30'd0, out_count}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_out_empty("bp_drain");

        // Count saturation with latency 1
        lat = 1;
        start_q.push_back({32'h3F800000, 32'h3F800000});
        start_q.push_back({32'h40000000, 32'h3F800000});
        start_q.push_back({32'h40400000, 32'h3F800000});
        start_q.push_back({32'h40800000, 32'h3F800000});
        sum_q.push_back(32'h40000000);
        sum_q.push_back(32'h40400000);
        sum_q.push_back(32'h40800000);
        sum_q.push_back(32'h40A00000);
        expect_out(32'h40A00000, 2'd3, 1'b0);
        send(32'h3F800000, 1'b0, w);
        send(32'h3F800000, 1'b0, w);
        send(32'h3F800000, 1'b0, w);
        chk("lat1_ready_gap", w, 32'd2);
        send(32'h3F800000, 1'b0, w);
        send(32'h3F800000, 1'b1, w);
        wait_out_empty("sat_drain");

        // Timeout: adder never answers, remaining operands drained
        lat = 100000;
        start_q.push_back({32'h3F800000, 32'h40000000});
        sum_q.push_back(32'h7FC00000);
        expect_out(32'h3F800000, 2'd2, 1'b1);
        send(32'h3F800000, 1'b0, w);
        send(32'h40000000, 1'b0, w);
        send(32'h40400000, 1'b0, w);
        chk("timeout_ready_gap", w, 32'd9);
        send(32'h40800000, 1'b1, w);
        wait_out_empty("timeout_drain");

        // Done on the final allowed WAIT cycle wins over timeout
        lat = TIMEOUT;
        start_q.push_back({32'h3F800000, 32'h40000000});
        sum_q.push_back(32'h40400000);
        expect_out(32'h40400000, 2'd2, 1'b0);
        send(32'h3F800000, 1'b0, w);
        send(32'h40000000, 1'b1, w);
        wait_out_empty("late_done_drain");

        // Reset while waiting on the adder
        lat = 100000;
        start_q.push_back({32'h3F800000, 32'h40000000});
        sum_q.push_back(32'h40400000);
        send(32'h3F800000, 1'b0, w);
        send(32'h40000000, 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_add_start", {31'd0, add_start}, 32'd0);
        chk("midrst_add_a", add_a, 32'd0);
        chk("midrst_add_b", add_b, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_count", {30'd0, out_count}, 32'd0);
        chk("midrst_out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 3.0 + (-3.0): sum is whatever the adder returns
        lat = 3;
        start_q.push_back({32'h40400000, 32'hC0400000});
        sum_q.push_back(32'h00000000);
        expect_out(32'h00000000, 2'd2, 1'b0);
        send(32'h40400000, 1'b0, w);
        send(32'hC0400000, 1'b1, w);
        wait_out_empty("post_rst_drain");

        chk("start_q_empty", start_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
